// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a data requester. Each access runs IDLE -> ISSUE -> WAIT -> RESP.
// Data wins collisions, but a burst of back-to-back data grants is capped
// so that a waiting fetch cannot be starved.
module mem_arbiter #(
    parameter int LATENCY      = 2,  // cycles from mem_en to valid mem_rdata (1..15)
    parameter int MAX_DM_BURST = 4   // max consecutive data grants while a fetch waits (1..15)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] LAT_INIT  = 4'(LATENCY);
    localparam logic [3:0] BURST_MAX = 4'(MAX_DM_BURST);

    logic [1:0]  r_state;
    logic [3:0]  r_streak;    // consecutive data grants taken while a fetch was waiting
    logic [3:0]  r_cnt;       // remaining WAIT cycles
    logic        r_owner_dm;  // 1 = access in flight belongs to the data port
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;     // word captured from memory at the end of WAIT

    logic w_any_req;
    logic w_grant_dm;
    logic w_resp;

    assign w_any_req  = if_req | dm_req;
    // Data wins a collision unless it has already used up its burst allowance.
    assign w_grant_dm = dm_req & (~if_req | (r_streak != BURST_MAX));

    // Access sequencer: grant and latch in IDLE, strobe memory, count latency, respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_streak   <= 4'd0;
            r_cnt      <= 4'd0;
            r_owner_dm <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples the
            // pre-edge values of the others, independent of statement order.
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= S_ISSUE;
                        r_owner_dm <= w_grant_dm;
                        if (w_grant_dm) begin
                            r_addr  <= dm_addr;
                            r_we    <= dm_we;
                            r_wdata <= dm_wdata;
                            if (if_req)
                                r_streak <= (r_streak == BURST_MAX) ? BURST_MAX
                                                                    : r_streak + 4'd1;
                            else
                                r_streak <= 4'd0;
                        end else begin
                            r_addr   <= if_addr;
                            r_we     <= 1'b0;
                            r_wdata  <= 32'd0;
                            r_streak <= 4'd0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                    r_cnt   <= LAT_INIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_rdata <= mem_rdata;
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The latched address and write data drive the memory bus directly, so
    // they naturally hold their last value outside ISSUE and clear on reset.
    assign busy      = (r_state != S_IDLE);
    assign mem_en    = (r_state == S_ISSUE);
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign w_resp   = (r_state == S_RESP);
    assign if_ready = w_resp & ~r_owner_dm;
    assign dm_ready = w_resp & r_owner_dm;
    assign if_rdata = if_ready ? r_rdata : 32'd0;
    // A store returns no data.
    assign dm_rdata = (dm_ready & ~r_we) ? r_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (LATENCY=2, MAX_DM_BURST=4).
// The memory model answers each access with addr ^ 32'hFFFF0000, two cycles
// after mem_en, and returns filler data otherwise.
module tb_mem_arbiter;

    localparam logic [31:0] MASK = 32'hFFFF0000;
    localparam logic [31:0] FILL = 32'hA5A5A5A5;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    logic [31:0] r_p1;
    logic [31:0] r_p2;

    int n_checks;
    int n_fail;

    mem_arbiter #(.LATENCY(2), .MAX_DM_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-stage memory read pipeline: data valid two cycles after mem_en.
    always @(posedge clk) begin
        r_p1 <= mem_en ? (mem_addr ^ MASK) : FILL;
        r_p2 <= r_p1;
    end
    assign mem_rdata = r_p2;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; outputs are settled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'd0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'd0;
        dm_wdata = 32'd0;

        // ---- Reset state ----
        #2;
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_mem_en",   {31'd0, mem_en},   32'd0);
        check("rst_mem_addr", mem_addr,          32'd0);
        check("rst_mem_wdat", mem_wdata,         32'd0);
        check("rst_if_ready", {31'd0, if_ready}, 32'd0);
        check("rst_dm_ready", {31'd0, dm_ready}, 32'd0);
        check("rst_if_rdata", if_rdata,          32'd0);
        check("rst_dm_rdata", dm_rdata,          32'd0);
        step();
        step();
        reset = 1'b0;

        // ---- Single fetch: cycle 0 request ----
        if_req  = 1'b1;
        if_addr = 32'h10;
        step(); // cycle 1
        check("f_c1_mem_en",   {31'd0, mem_en}, 32'd1);
        check("f_c1_mem_addr", mem_addr,        32'h10);
        check("f_c1_mem_we",   {31'd0, mem_we}, 32'd0);
        step(); // cycle 2
        check("f_c2_mem_en",   {31'd0, mem_en}, 32'd0);
        check("f_c2_mem_addr", mem_addr,        32'h10);
        step(); // cycle 3
        check("f_c3_if_ready", {31'd0, if_ready}, 32'd0);
        step(); // cycle 4
        check("f_c4_if_ready", {31'd0, if_ready}, 32'd1);
        check("f_c4_if_rdata", if_rdata,          32'hFFFF0010);
        check("f_c4_dm_ready", {31'd0, dm_ready}, 32'd0);
        check("f_c4_busy",     {31'd0, busy},     32'd1);
        if_req = 1'b0;
        step(); // cycle 5
        check("f_c5_busy",     {31'd0, busy},     32'd0);
        check("f_c5_if_ready", {31'd0, if_ready}, 32'd0);
        check("f_c5_if_rdata", if_rdata,          32'd0);

        // ---- Address change and request drop after grant ----
        if_req  = 1'b1;
        if_addr = 32'h10;
        step(); // cycle 1
        if_addr = 32'h99;
        if_req  = 1'b0;
        #1;
        check("chg_c1_mem_addr", mem_addr, 32'h10);
        step(); // cycle 2
        step(); // cycle 3
        step(); // cycle 4
        check("chg_c4_if_ready", {31'd0, if_ready}, 32'd1);
        check("chg_c4_if_rdata", if_rdata,          32'hFFFF0010);
        step(); // cycle 5
        check("chg_c5_busy", {31'd0, busy}, 32'd0);

        // ---- Request dropped before grant: no access ----
        dm_req  = 1'b1;
        dm_addr = 32'h77;
        #2;
        dm_req  = 1'b0;
        step();
        check("drop_busy",   {31'd0, busy},   32'd0);
        check("drop_mem_en", {31'd0, mem_en}, 32'd0);

        // ---- Collision: data load first, then fetch ----
        if_req  = 1'b1;
        if_addr = 32'h30;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h20;
        step(); // cycle 1
        check("col_c1_mem_addr", mem_addr,        32'h20);
        check("col_c1_mem_en",   {31'd0, mem_en}, 32'd1);
        step();
        step();
        step(); // cycle 4
        check("col_c4_dm_ready", {31'd0, dm_ready}, 32'd1);
        check("col_c4_dm_rdata", dm_rdata,          32'hFFFF0020);
        check("col_c4_if_ready", {31'd0, if_ready}, 32'd0);
        check("col_c4_if_rdata", if_rdata,          32'd0);
        dm_req = 1'b0;
        step(); // cycle 5: fetch granted at the end of this cycle
        check("col_c5_busy", {31'd0, busy}, 32'd0);
        step(); // cycle 6
        check("col_c6_mem_addr", mem_addr,        32'h30);
        check("col_c6_mem_en",   {31'd0, mem_en}, 32'd1);
        step();
        step();
        step(); // cycle 9
        check("col_c9_if_ready", {31'd0, if_ready}, 32'd1);
        check("col_c9_if_rdata", if_rdata,          32'hFFFF0030);
        check("col_c9_dm_ready", {31'd0, dm_ready}, 32'd0);
        if_req = 1'b0;
        step();

        // ---- Store ----
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h40;
        dm_wdata = 32'hDEADBEEF;
        step(); // cycle 1
        check("st_c1_mem_en",    {31'd0, mem_en}, 32'd1);
        check("st_c1_mem_we",    {31'd0, mem_we}, 32'd1);
        check("st_c1_mem_addr",  mem_addr,        32'h40);
        check("st_c1_mem_wdata", mem_wdata,       32'hDEADBEEF);
        step(); // cycle 2
        check("st_c2_mem_we",    {31'd0, mem_we}, 32'd0);
        check("st_c2_mem_wdata", mem_wdata,       32'hDEADBEEF);
        step();
        step(); // cycle 4
        check("st_c4_dm_ready", {31'd0, dm_ready}, 32'd1);
        check("st_c4_dm_rdata", dm_rdata,          32'd0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        step();

        // ---- Starvation guard: four data grants, then one fetch ----
        if_req  = 1'b1;
        if_addr = 32'h50;
        dm_req  = 1'b1;
        dm_addr = 32'h60;
        for (int k = 0; k < 6; k++) begin
            step(); // cycle 1 of access k
            check($sformatf("stv%0d_mem_addr", k), mem_addr, (k == 4) ? 32'h50 : 32'h60);
            step();
            step();
            step(); // cycle 4 of access k
            check($sformatf("stv%0d_dm_ready", k), {31'd0, dm_ready}, (k == 4) ? 32'd0 : 32'd1);
            check($sformatf("stv%0d_if_ready", k), {31'd0, if_ready}, (k == 4) ? 32'd1 : 32'd0);
            step(); // IDLE, next grant at end of this cycle
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        step();

        // ---- Reset in the middle of WAIT ----
        if_req  = 1'b1;
        if_addr = 32'h70;
        step(); // cycle 1
        step(); // cycle 2 (WAIT)
        check("rw_c2_busy", {31'd0, busy}, 32'd1);
        reset  = 1'b1;
        if_req = 1'b0;
        #1;
        check("rw_async_busy",     {31'd0, busy},   32'd0);
        check("rw_async_mem_addr", mem_addr,        32'd0);
        check("rw_async_mem_en",   {31'd0, mem_en}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rw_hold%0d_if_ready", k), {31'd0, if_ready}, 32'd0);
        end
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h80;
        step(); // cycle 1
        check("rw_new_c1_mem_en",   {31'd0, mem_en}, 32'd1);
        check("rw_new_c1_mem_addr", mem_addr,        32'h80);
        step();
        step(); // cycle 3
        check("rw_new_c3_if_ready", {31'd0, if_ready}, 32'd0);
        step(); // cycle 4
        check("rw_new_c4_if_ready", {31'd0, if_ready}, 32'd1);
        check("rw_new_c4_if_rdata", if_rdata,          32'hFFFF0080);
        if_req = 1'b0;
        step(); // cycle 5
        check("rw_new_c5_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Parameters
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles from mem_en high to mem_rdata valid (legal range 1..15).
REQ-002 The block SHALL have parameter MAX_DM_BURST, default 4, meaning the maximum number of consecutive data grants while a fetch is pending (legal range 1..15).

Interface
REQ-003 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  32  fetch address
- if_rdata  out  32  fetch data, valid while if_ready
- if_ready  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request, held until dm_ready
- dm_we  in  1  data write enable (1 = store, 0 = load)
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data, valid while dm_ready
- dm_ready  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid LATENCY cycles after mem_en
- busy  out  1  high whenever state is not IDLE

Function
REQ-004 The block SHALL implement four states: IDLE, ISSUE, WAIT, RESP.
REQ-005 In IDLE, if either request is high at a clock edge, the block SHALL latch the winner's address, we and wdata, and go to ISSUE; with no request it SHALL stay in IDLE.
REQ-006 A fetch has we forced to 0 and wdata forced to 0.
REQ-007 Arbitration: dm wins when both requests are high, except when streak == MAX_DM_BURST, in which case if wins.
REQ-008 streak SHALL increment on a dm grant while if_req is high, saturating at MAX_DM_BURST.
REQ-009 streak SHALL clear on an if grant and on a dm grant while if_req is low.
REQ-010 ISSUE SHALL last exactly one cycle with mem_en = 1 and mem_we/mem_addr/mem_wdata from the latched values, then go to WAIT with cnt = LATENCY.
REQ-011 In all states other than ISSUE, mem_en and mem_we SHALL be 0, and mem_addr/mem_wdata SHALL hold their last value.
REQ-012 WAIT SHALL decrement cnt each cycle; in the cycle cnt == 1 the block SHALL capture mem_rdata and go to RESP.
REQ-013 RESP SHALL last one cycle, asserting only the owner's ready, then go to IDLE.
- For a load or fetch, the owner's rdata SHALL equal the captured word.
- For a store, dm_rdata SHALL be 0.
- The non-owner's ready and rdata SHALL be 0.
REQ-014 Requests SHALL be ignored in ISSUE, WAIT and RESP. The earliest new grant is the IDLE cycle after RESP, so back-to-back accesses are spaced LATENCY+3 cycles apart.
REQ-015 A request dropped before its grant SHALL cause no access. A request dropped after its grant SHALL still complete, with ready pulsed.
REQ-016 Inputs SHALL be sampled only at the grant edge; later changes to addr, wdata or we SHALL not affect the access in flight.
REQ-017 Timing: a request granted at the cycle-0 edge gives mem_en in cycle 1, mem_rdata sampled in cycle 1+LATENCY, and ready in cycle 2+LATENCY.

Reset
REQ-018 Asserting reset SHALL immediately, without waiting for a clock edge, force state = IDLE, streak = 0 and cnt = 0.
REQ-019 During reset, all outputs SHALL be 0, including mem_addr, mem_wdata, if_rdata and dm_rdata.
REQ-020 Reset during ISSUE, WAIT or RESP SHALL abandon the access with no ready pulse. The first edge after reset is released behaves as IDLE.

Verification (LATENCY=2, MAX_DM_BURST=4, memory model returns addr^32'hFFFF0000)
REQ-021 Single fetch: if_req=1, if_addr=0x10 at cycle 0 -> mem_en=1 and mem_addr=0x10 in cycle 1; if_ready=1 and if_rdata=0xFFFF0010 in cycle 4; busy low in cycle 5.
REQ-022 Collision: if_req and dm_req (load 0x20) both high at cycle 0 -> the dm access goes first (dm_ready in cycle 4); the fetch is granted in cycle 5 and if_ready pulses in cycle 9.
REQ-023 Starvation guard: dm_req held high continuously together with if_req -> exactly 4 dm grants, then an if grant, then streak restarts from 0.
REQ-024 Store: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF -> in cycle 1 mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF; dm_ready=1 with dm_rdata=0 in cycle 4.
REQ-025 Reset mid-WAIT: assert reset in cycle 2 of a fetch -> all outputs 0 at once; no if_ready pulse; a new if_req after release completes normally with 5-cycle timing.
REQ-026 Input change after grant: change if_addr to 0x99 in cycle 1 -> mem_addr stays 0x10; if_rdata=0xFFFF0010.
